// File: rtl/sap1_control_sequencer.sv
// sap1_control_sequencer: decodes SAP-1 T-state ring + IR opcode into the 12-bit control word
// Ports: clk/rst (sync, active-high); tstate one-hot T1..T6 (0 = T0 bubble); opcode = IR[7:4];
//        ctrl = {cp,ep,lm,ce,li,ei,la,ea,su,eu,lb,lo}; hlt halt latch; clk_en = ~hlt;
//        fault sticky sequence error; instr_count retired instructions (wraps).
module sap1_control_sequencer #(
  parameter int CNT_W       = 8,
  parameter bit FAULT_HALTS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       tstate,
  input  logic [3:0]       opcode,
  output logic [11:0]      ctrl,
  output logic             hlt,
  output logic             clk_en,
  output logic             fault,
  output logic [CNT_W-1:0] instr_count
);
  logic             hlt_q, hlt_d;
  logic             fault_q, fault_d;
  logic [5:0]       shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             legal, mis, alu_op;
  // one-hot or all-zero; shadow is always legal so any illegal state also mismatches
  assign legal  = (tstate & (tstate - 6'd1)) == 6'd0;
  assign mis    = (tstate != shadow_q) || !legal;
  assign alu_op = (opcode == 4'h1) || (opcode == 4'h2);
  always_comb begin
    ctrl = 12'h000;
    if (!rst && !hlt_q && legal)
      case (tstate)
        6'b000001: ctrl = 12'h600;
        6'b000010: ctrl = 12'h800;
        6'b000100: ctrl = 12'h180;
        6'b001000: ctrl = (opcode == 4'h0 || alu_op) ? 12'h240 : (opcode == 4'hE) ? 12'h011 : 12'h000;
        6'b010000: ctrl = (opcode == 4'h0) ? 12'h120 : alu_op ? 12'h102 : 12'h000;
        6'b100000: ctrl = (opcode == 4'h1) ? 12'h024 : (opcode == 4'h2) ? 12'h02C : 12'h000;
        default:   ctrl = 12'h000;
      endcase
  end
  // everything but the halt latch itself freezes while halted
  always_comb begin
    hlt_d    = hlt_q;
    fault_d  = fault_q;
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    if (!hlt_q) begin
      hlt_d    = (tstate == 6'b001000 && opcode == 4'hF) || (FAULT_HALTS && mis);
      fault_d  = fault_q || mis;
      // resync to the observed ring position; successor of T6 (100000) shifts out to T0
      shadow_d = !legal ? 6'b000001 : (tstate == 6'd0) ? 6'b000001 : tstate << 1;
      cnt_d    = (tstate == 6'b100000 && !mis) ? cnt_q + CNT_W'(1) : cnt_q;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      hlt_q    <= 1'b0;
      fault_q  <= 1'b0;
      shadow_q <= 6'b000001;
      cnt_q    <= '0;
    end else begin
      hlt_q    <= hlt_d;
      fault_q  <= fault_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end
  assign hlt         = hlt_q;
  assign clk_en      = ~hlt_q;
  assign fault       = fault_q;
  assign instr_count = cnt_q;
endmodule

// File: tb/tb_sap1_control_sequencer.sv
// tb_sap1_control_sequencer: scoreboard bench for two sequencer instances (FAULT_HALTS=0 and 1)
module tb_sap1_control_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  ts  = 6'b000001;
  logic [3:0]  op  = 4'h0;
  logic [11:0] ctrl0, ctrl1;
  logic        hlt0, hlt1, en0, en1, flt0, flt1;
  logic [7:0]  cnt0, cnt1;
  int          checks = 0;
  int          errors = 0;
  // w: 0 = check dut0 only, 1 = dut1 only, 2 = both; r: registered outputs are defined
  typedef struct packed {
    logic [11:0] c;
    logic        h;
    logic        f;
    logic [7:0]  n;
    logic [1:0]  w;
    logic        r;
  } exp_t;
  exp_t q[$];
  sap1_control_sequencer #(.CNT_W(8), .FAULT_HALTS(1'b0)) dut0 (
    .clk(clk), .rst(rst), .tstate(ts), .opcode(op), .ctrl(ctrl0),
    .hlt(hlt0), .clk_en(en0), .fault(flt0), .instr_count(cnt0));
  sap1_control_sequencer #(.CNT_W(8), .FAULT_HALTS(1'b1)) dut1 (
    .clk(clk), .rst(rst), .tstate(ts), .opcode(op), .ctrl(ctrl1),
    .hlt(hlt1), .clk_en(en1), .fault(flt1), .instr_count(cnt1));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [11:0] a, input logic [11:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, a, x, $time);
    end
  endtask
  // monitor: outputs are sampled mid low-phase, after stimulus settles and before the edge
  initial forever begin
    exp_t e;
    @(negedge clk);
    #2;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.w != 2'd1) begin
        chk("d0_ctrl", ctrl0, e.c);
        if (e.r) begin
          chk("d0_hlt", {11'd0, hlt0}, {11'd0, e.h});
          chk("d0_clk_en", {11'd0, en0}, {11'd0, ~e.h});
          chk("d0_fault", {11'd0, flt0}, {11'd0, e.f});
          chk("d0_count", {4'd0, cnt0}, {4'd0, e.n});
        end
      end
      if (e.w != 2'd0) begin
        chk("d1_ctrl", ctrl1, e.c);
        if (e.r) begin
          chk("d1_hlt", {11'd0, hlt1}, {11'd0, e.h});
          chk("d1_clk_en", {11'd0, en1}, {11'd0, ~e.h});
          chk("d1_fault", {11'd0, flt1}, {11'd0, e.f});
          chk("d1_count", {4'd0, cnt1}, {4'd0, e.n});
        end
      end
    end
  end
  task automatic step(input logic r, input logic [5:0] t, input logic [3:0] o, input logic [11:0] c,
                      input logic h, input logic f, input logic [7:0] n, input logic [1:0] w, input logic rg);
    @(negedge clk);
    rst = r;
    ts  = t;
    op  = o;
    q.push_back('{c: c, h: h, f: f, n: n, w: w, r: rg});
  endtask
  task automatic reset2(input logic [1:0] w);
    step(1'b1, 6'b000001, 4'h0, 12'h000, 1'b0, 1'b0, 8'd0, w, 1'b0);
    step(1'b1, 6'b000001, 4'h0, 12'h000, 1'b0, 1'b0, 8'd0, w, 1'b1);
  endtask
  // full instruction T1..T6 plus the T0 bubble; count n before, n+1 visible in T0
  task automatic instr(input logic [3:0] o, input logic [11:0] c4, input logic [11:0] c5,
                       input logic [11:0] c6, input logic [7:0] n, input logic [1:0] w);
    step(1'b0, 6'b000001, o, 12'h600, 1'b0, 1'b0, n, w, 1'b1);
    step(1'b0, 6'b000010, o, 12'h800, 1'b0, 1'b0, n, w, 1'b1);
    step(1'b0, 6'b000100, o, 12'h180, 1'b0, 1'b0, n, w, 1'b1);
    step(1'b0, 6'b001000, o, c4,      1'b0, 1'b0, n, w, 1'b1);
    step(1'b0, 6'b010000, o, c5,      1'b0, 1'b0, n, w, 1'b1);
    step(1'b0, 6'b100000, o, c6,      1'b0, 1'b0, n, w, 1'b1);
    step(1'b0, 6'b000000, o, 12'h000, 1'b0, 1'b0, n + 8'd1, w, 1'b1);
  endtask
  initial begin
    logic [5:0] junk [5];
    junk = '{6'b010000, 6'b100000, 6'b000000, 6'b000001, 6'b000011};
    // LDA
    reset2(2'd2);
    instr(4'h0, 12'h240, 12'h120, 12'h000, 8'd0, 2'd2);
    // ADD then SUB
    reset2(2'd2);
    instr(4'h1, 12'h240, 12'h102, 12'h024, 8'd0, 2'd2);
    instr(4'h2, 12'h240, 12'h102, 12'h02C, 8'd1, 2'd2);
    // OUT then HLT; halted machine ignores ring, including T6 and junk states
    reset2(2'd2);
    instr(4'hE, 12'h011, 12'h000, 12'h000, 8'd0, 2'd2);
    step(1'b0, 6'b000001, 4'hF, 12'h600, 1'b0, 1'b0, 8'd1, 2'd2, 1'b1);
    step(1'b0, 6'b000010, 4'hF, 12'h800, 1'b0, 1'b0, 8'd1, 2'd2, 1'b1);
    step(1'b0, 6'b000100, 4'hF, 12'h180, 1'b0, 1'b0, 8'd1, 2'd2, 1'b1);
    step(1'b0, 6'b001000, 4'hF, 12'h000, 1'b0, 1'b0, 8'd1, 2'd2, 1'b1);
    for (int i = 0; i < 10; i++)
      step(1'b0, junk[i % 5], 4'hF, 12'h000, 1'b1, 1'b0, 8'd1, 2'd2, 1'b1);
    step(1'b1, 6'b000001, 4'h0, 12'h000, 1'b1, 1'b0, 8'd1, 2'd2, 1'b1);
    step(1'b0, 6'b000001, 4'h0, 12'h600, 1'b0, 1'b0, 8'd0, 2'd2, 1'b1);
    // skipped T3 on the flag-only instance; resynced instruction still retires
    reset2(2'd2);
    step(1'b0, 6'b000001, 4'h0, 12'h600, 1'b0, 1'b0, 8'd0, 2'd0, 1'b1);
    step(1'b0, 6'b000010, 4'h0, 12'h800, 1'b0, 1'b0, 8'd0, 2'd0, 1'b1);
    step(1'b0, 6'b001000, 4'h0, 12'h240, 1'b0, 1'b0, 8'd0, 2'd0, 1'b1);
    step(1'b0, 6'b010000, 4'h0, 12'h120, 1'b0, 1'b1, 8'd0, 2'd0, 1'b1);
    step(1'b0, 6'b100000, 4'h0, 12'h000, 1'b0, 1'b1, 8'd0, 2'd0, 1'b1);
    step(1'b0, 6'b000000, 4'h0, 12'h000, 1'b0, 1'b1, 8'd1, 2'd0, 1'b1);
    step(1'b0, 6'b000001, 4'h0, 12'h600, 1'b0, 1'b1, 8'd1, 2'd0, 1'b1);
    // non-one-hot state: ctrl zero immediately, halting instance stops next cycle
    reset2(2'd2);
    step(1'b0, 6'b000001, 4'h0, 12'h600, 1'b0, 1'b0, 8'd0, 2'd2, 1'b1);
    step(1'b0, 6'b000011, 4'h0, 12'h000, 1'b0, 1'b0, 8'd0, 2'd2, 1'b1);
    step(1'b0, 6'b000100, 4'h0, 12'h000, 1'b1, 1'b1, 8'd0, 2'd1, 1'b1);
    // counter wrap, then reset in the middle of an instruction
    reset2(2'd2);
    for (int i = 0; i < 256; i++)
      instr(4'h5, 12'h000, 12'h000, 12'h000, 8'(i), 2'd2);
    instr(4'h5, 12'h000, 12'h000, 12'h000, 8'd0, 2'd2);
    step(1'b0, 6'b000001, 4'h5, 12'h600, 1'b0, 1'b0, 8'd1, 2'd2, 1'b1);
    step(1'b0, 6'b000010, 4'h5, 12'h800, 1'b0, 1'b0, 8'd1, 2'd2, 1'b1);
    step(1'b0, 6'b000100, 4'h5, 12'h180, 1'b0, 1'b0, 8'd1, 2'd2, 1'b1);
    step(1'b1, 6'b001000, 4'h5, 12'h000, 1'b0, 1'b0, 8'd1, 2'd2, 1'b1);
    step(1'b0, 6'b000001, 4'h5, 12'h600, 1'b0, 1'b0, 8'd0, 2'd2, 1'b1);
    step(1'b0, 6'b000010, 4'h5, 12'h800, 1'b0, 1'b0, 8'd0, 2'd2, 1'b1);
    step(1'b0, 6'b000100, 4'h5, 12'h180, 1'b0, 1'b0, 8'd0, 2'd2, 1'b1);
    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(negedge clk);
    #3;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain %0d entries left, expected 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sap1_control_sequencer.md
Name: sap1_control_sequencer

Overview:
Consumer end of the SAP-1 T-state ring: decodes the 6-bit one-hot timing state plus the IR opcode into the 12-bit SAP-1 control word. Also keeps a shadow copy of the ring sequence and flags desynchronisation or non-one-hot states. Latches HLT and gates the machine clock enable. Counts retired instructions. Sits between the ring counter / IR and the datapath (PC, MAR, RAM, IR, A, B, ALU, OUT).

Parameters:
CNT_W, 8, width of retired-instruction counter (wraps modulo 2^CNT_W)
FAULT_HALTS, 1, 1 = a fault also sets the halt latch; 0 = fault is flag-only

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
tstate  input  6  ring count; bit0=T1 … bit5=T6; 6'b000000 = legal bubble state T0
opcode  input  4  IR upper nibble
ctrl  output  12  control word, active-high: [11]cp [10]ep [9]lm [8]ce [7]li [6]ei [5]la [4]ea [3]su [2]eu [1]lb [0]lo
hlt  output  1  halt latch
clk_en  output  1  = ~hlt; enables ring counter and datapath registers
fault  output  1  sticky sequence fault
instr_count  output  CNT_W  retired-instruction count

Behaviour:
- Reset (rst=1 at rising edge): hlt=0, fault=0, instr_count=0, shadow=6'b000001. ctrl is forced to 0 in any cycle where rst=1. rst overrides all other events, including mid-instruction.
- Legal sequence (7 states): 000001→000010→000100→001000→010000→100000→000000→000001. The shadow register advances one step per cycle while hlt=0 and is frozen while hlt=1.
- ctrl is combinational from tstate, opcode and hlt. It is 0 when hlt=1, when rst=1, or when tstate is neither one-hot nor zero.
  - T0: 0
  - T1: ep,lm
  - T2: cp
  - T3: ce,li
  - T4/T5/T6 by opcode:
    - LDA 0000: T4 ei,lm; T5 ce,la; T6 0
    - ADD 0001: T4 ei,lm; T5 ce,lb; T6 la,eu
    - SUB 0010: T4 ei,lm; T5 ce,lb; T6 la,eu,su
    - OUT 1110: T4 ea,lo; T5 0; T6 0
    - HLT 1111: T4–T6 0
    - Any other opcode: NOP, all-zero in T4–T6
- Halt: at a rising edge with hlt=0, tstate=001000 and opcode=1111, hlt←1. It is cleared only by rst. clk_en=~hlt takes effect the same cycle hlt rises.
- Fault check applies each edge with hlt=0:
  - If tstate≠shadow, or tstate has more than one bit set: fault←1 (sticky until rst).
  - If FAULT_HALTS=1, hlt←1 on the same edge.
  - Resync: if tstate is legal (one-hot or zero), shadow←successor(tstate); otherwise shadow←000001.
- Retire: at an edge with hlt=0, tstate=100000 and no fault detected that cycle, instr_count←instr_count+1, wrapping at all-ones→0. HLT never reaches T6, so it never retires.
- Simultaneous events:
  - HLT detect and fault on the same edge: both set.
  - Retire and fault on the same edge: fault wins, no increment.
- Latency:
  - ctrl: 0 cycles.
  - hlt, fault, instr_count: visible 1 cycle after the qualifying edge.

Test Plan:
1. rst=1 two cycles, then drive the legal 7-state sequence with opcode=0000 → ctrl T1=0x600, T2=0x800, T3=0x180, T4=0x240, T5=0x120, T6/T0=0x000; instr_count=1 after the T6 edge; fault=0.
2. ADD then SUB (opcodes 0001, 0010) → T5=0x102, T6=0x024 for ADD and 0x02C for SUB; instr_count=2.
3. OUT then HLT (1110, 1111) → OUT T4=0x011; HLT: hlt=1 and clk_en=0 one cycle after the T4 edge; ctrl=0 thereafter; instr_count stays 1 for 10 further cycles; rst clears hlt.
4. Skip a state (T2 followed by 001000 instead of 000100), FAULT_HALTS=0 → fault=1 next cycle; shadow resyncs, so continuing 010000,100000 gives no new mismatch; T6 of the resynced instruction retires (count increments).
5. Drive tstate=000011 → ctrl=0 the same cycle; fault=1 next cycle; with FAULT_HALTS=1, hlt=1 and clk_en=0.
6. Run 256 NOP instructions (opcode 0101, CNT_W=8) → instr_count wraps 255→0. Assert rst during T4 → the next cycle shows shadow=000001, count=0, flags=0, and ctrl=0 during the rst cycle.
